rr_packet_arbiter: RTL
======================

// Module: rr_packet_arbiter
// PURPOSE
//  Per-output-port wormhole arbiter for the 2x2 mesh router. It sits between the per-input
//  flowcontrol ready signals and one xbar/output_buffer pair.
//  Locks the output to one input port from header flit to tail flit, counts flits against
//  the header length field, and rotates round-robin priority on packet release.
//  grant drives the FIFO rd_en OR-tree; sel drives the xbar select.
// PARAMETERS
//  N_REQ           3    number of input ports (requesters); bit i = port i
//  LEN_W           12   width of per-port length field (packet flits minus 1)
//  TIMEOUT_CYCLES  255  stall limit in LOCK; used only when ARB_TIMEOUT_EN is defined
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            synchronous reset, active-high
//  req        in   N_REQ        per-port request: fc_ready_out for this output
//  flit_type  in   3*N_REQ      per-port one-hot type, [3i+2:3i]; 001=HDR 010=BODY 100=TAIL
//  length     in   LEN_W*N_REQ  per-port header length minus 1; sampled on HDR grant only
//  out_ready  in   1            downstream DCTS for this output
//  grant      out  N_REQ        one-hot; combinational; the flit of port i transfers this cycle
//  sel        out  N_REQ        registered one-hot owner, to xbar; 0 when idle
//  busy       out  1            registered; 1 while in LOCK
//  len_err    out  1            registered one-cycle pulse: length/tail mismatch
//  tmo_err    out  1            registered one-cycle pulse: lock timeout (0 if feature off)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE, ptr=0, cnt=0, sel=0, busy=0, len_err=0,
//    tmo_err=0, stall=0. grant is forced to 0 while rst=1.
//  - Eligible(i) = req[i] && flit_type[i]==HDR. A BODY or TAIL flit at a non-owner is never granted.
//  - IDLE:
//    - If out_ready=1, grant the first eligible port scanning ptr, ptr+1, ..., wrapping mod N_REQ.
//      Zero-cycle latency from req to grant.
//    - On the grant edge with len=0 (single-flit packet): stay IDLE, ptr <= winner+1 mod N_REQ.
//    - Else: state <= LOCK, owner <= winner, sel <= onehot(winner), busy <= 1,
//      cnt <= length[winner].
//  - LOCK:
//    - grant[owner] = req[owner] && out_ready. All other grant bits are 0. New headers wait.
//    - Each granted flit decrements cnt.
//    - The release condition is a grant with (cnt==1 || flit_type[owner]==TAIL).
//    - On release: state <= IDLE, sel <= 0, busy <= 0, ptr <= owner+1 mod N_REQ.
//    - len_err <= 1 for one cycle if TAIL arrives with cnt!=1, or if cnt==1 and the flit is not TAIL.
//      In both cases the lock is still released.
//  - Simultaneous eligible headers resolve by the ptr order only. ptr changes only on release
//    or on a single-flit grant.
//  - A grant is never given while out_ready=0; state and cnt hold.
//  - Reset asserted mid-packet abandons the lock immediately with the values above.
//    No partial-packet recovery is performed.
//  - cnt is LEN_W bits and is never decremented below 1 in LOCK, so it cannot wrap.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//    - stall counter, $clog2(TIMEOUT_CYCLES+1) bits.
//    - Counts consecutive LOCK cycles with no grant and clears on any grant or on leaving LOCK.
//    - On reaching TIMEOUT_CYCLES: release as above, tmo_err pulses one cycle, len_err stays 0.
//  ARB_TIMEOUT_EN undefined: no stall counter. tmo_err is tied to 0. LOCK is held indefinitely.
// TESTING
//  1. Port1 sends HDR len=3 (4 flits) with out_ready=1 -> grant=010 on 4 consecutive cycles.
//     busy=1 for cycles 2-4; ptr=2 afterwards; len_err=0.
//  2. HDR on all ports in the same cycle with ptr=0, each len=1 -> grant order 001,001,010,010,100,100.
//  3. Port0 locked and port2 presents HDR -> grant stays 0 for port2 until port0's TAIL is granted.
//     Port2 is granted on the next cycle.
//  4. out_ready=0 for 5 cycles mid-packet -> grant=0, cnt held. The packet completes once
//     out_ready=1 with no len_err.
//  5. HDR len=5 with TAIL on the 3rd flit -> release on the TAIL cycle and len_err pulses exactly 1 cycle.
//  6. rst=1 during LOCK -> next cycle busy=0, sel=000, grant=000.
//     With ARB_TIMEOUT_EN: owner req=0 for 255 cycles -> release and tmo_err=1 for 1 cycle.

Source files
------------

// File: rtl/rr_packet_arbiter.sv
// Wormhole round-robin arbiter for one mesh-router output. It locks the output to one input from
// the header flit to the tail flit. Define ARB_TIMEOUT_EN to release a lock that has stalled too long.
module rr_packet_arbiter #(
    parameter int N_REQ          = 3,
    parameter int LEN_W          = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [3*N_REQ-1:0]       flit_type,
    input  logic [LEN_W*N_REQ-1:0]   length,
    input  logic                     out_ready,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         sel,
    output logic                     busy,
    output logic                     len_err,
    output logic                     tmo_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [2:0] FT_HDR  = 3'b001;
    localparam logic [2:0] FT_TAIL = 3'b100;

    typedef enum logic {ST_IDLE, ST_LOCK} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [LEN_W-1:0]   cnt_reg, cnt_next;
    logic [N_REQ-1:0]   sel_reg, sel_next;
    logic               busy_reg, busy_next;
    logic               len_err_reg, len_err_next;
    logic [N_REQ-1:0]   grant_int;

    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   is_tail;
    logic [LEN_W-1:0]   len_arr [N_REQ];
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_port
            assign eligible[gi] = req[gi] && (flit_type[3*gi +: 3] == FT_HDR);
            assign is_tail[gi]  = (flit_type[3*gi +: 3] == FT_TAIL);
            assign len_arr[gi]  = length[LEN_W*gi +: LEN_W];
        end
    endgenerate

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(N_REQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    // First eligible header starting at ptr, wrapping around the ports.
    always_comb begin
        int pos;
        win_found = 1'b0;
        win_idx   = ptr_reg;
        pos       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(ptr_reg) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            if (!win_found && eligible[pos]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(pos);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall_reg, stall_next;
    logic               tmo_err_reg, tmo_err_next;
`endif

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        ptr_next     = ptr_reg;
        cnt_next     = cnt_reg;
        sel_next     = sel_reg;
        busy_next    = busy_reg;
        len_err_next = 1'b0;
        grant_int    = '0;
`ifdef ARB_TIMEOUT_EN
        stall_next   = '0;
        tmo_err_next = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (out_ready && win_found) begin
                    grant_int[win_idx] = 1'b1;
                    if (len_arr[win_idx] == '0) begin
                        ptr_next = next_idx(win_idx);
                    end else begin
                        state_next         = ST_LOCK;
                        owner_next         = win_idx;
                        sel_next           = '0;
                        sel_next[win_idx]  = 1'b1;
                        busy_next          = 1'b1;
                        cnt_next           = len_arr[win_idx];
                    end
                end
            end
            ST_LOCK: begin
                if (req[owner_reg] && out_ready) begin
                    grant_int[owner_reg] = 1'b1;
                    if (cnt_reg == LEN_W'(1) || is_tail[owner_reg]) begin
                        state_next   = ST_IDLE;
                        sel_next     = '0;
                        busy_next    = 1'b0;
                        ptr_next     = next_idx(owner_reg);
                        // Clean only when the count runs out exactly on the tail.
                        len_err_next = !(cnt_reg == LEN_W'(1) && is_tail[owner_reg]);
                    end else begin
                        cnt_next = cnt_reg - LEN_W'(1);
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (stall_reg == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next   = ST_IDLE;
                    sel_next     = '0;
                    busy_next    = 1'b0;
                    ptr_next     = next_idx(owner_reg);
                    tmo_err_next = 1'b1;
                end else begin
                    stall_next = stall_reg + STALL_W'(1);
                end
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            owner_reg   <= '0;
            ptr_reg     <= '0;
            cnt_reg     <= '0;
            sel_reg     <= '0;
            busy_reg    <= 1'b0;
            len_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            ptr_reg     <= ptr_next;
            cnt_reg     <= cnt_next;
            sel_reg     <= sel_next;
            busy_reg    <= busy_next;
            len_err_reg <= len_err_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_reg   <= '0;
            tmo_err_reg <= 1'b0;
        end else begin
            stall_reg   <= stall_next;
            tmo_err_reg <= tmo_err_next;
        end
    end
    assign tmo_err = tmo_err_reg;
`else
    assign tmo_err = 1'b0;
`endif

    assign grant   = rst ? '0 : grant_int;
    assign sel     = sel_reg;
    assign busy    = busy_reg;
    assign len_err = len_err_reg;

endmodule
